counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command-driven controller that sequences a WIDTH-bit up-counter: start/stop/load/clear via a valid/ready command port, prescaled counting, limit compare with one-shot or auto-reload behaviour, and a done event. It wraps the free-running counter datapath so software-visible logic and testbenches drive one control port instead of raw clock-enable wiring.

## Interface
- WIDTH, 32, counter and limit width
- PW, 8, prescaler width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
- cmd_op  in  2  0=START, 1=STOP, 2=LOAD, 3=CLEAR
- cmd_data  in  WIDTH  load value (LOAD only)
- cfg_limit  in  WIDTH  compare value, sampled every cycle
- cfg_reload  in  1  1=auto-reload, 0=one-shot
- cfg_prescale  in  PW  tick every cfg_prescale+1 RUN cycles
- out  out  WIDTH  counter value (registered)
- busy  out  1  state==RUN
- done_pulse  out  1  one-cycle limit event (registered)
- done_cnt  out  8  saturating count of done events

## Operation
- States: IDLE, RUN, PAUSED, DONE. Internal prescaler presc[PW-1:0].
- tick = (state==RUN) & (presc >= cfg_prescale). In RUN: tick -> presc<=0, else presc<=presc+1. Outside RUN presc holds.
- On tick: if out==cfg_limit: done_pulse<=1, done_cnt<=sat(done_cnt+1); cfg_reload=1 -> out<=0, stay RUN; cfg_reload=0 -> out holds, state<=DONE. Else out<=out+1 (mod 2^WIDTH; equality compare only, so LOAD above limit wraps through 0 before matching).
- cmd_ready = !tick (combinational): commands never coincide with a counter update. 1 in IDLE, PAUSED, DONE.
- Accepted commands, by state:
- IDLE: START -> RUN, presc<=0. LOAD -> out<=cmd_data. CLEAR -> out<=0, done_cnt<=0. STOP no-op.
- RUN: STOP -> PAUSED (presc held). LOAD -> out<=cmd_data, presc<=0. CLEAR -> out<=0, presc<=0, done_cnt<=0. START no-op.
- PAUSED: START -> RUN, presc resumes from held value. LOAD/CLEAR as in IDLE, stay PAUSED. STOP no-op.
- DONE: START -> out<=0, presc<=0, RUN. LOAD -> out<=cmd_data, IDLE. CLEAR -> out<=0, done_cnt<=0, IDLE. STOP -> IDLE.
- cfg_* changes take effect the same cycle; lowering cfg_prescale below presc forces tick next RUN cycle (>= compare).
- done_cnt saturates at 255.

## Timing
- Reset (rst_n=0, async): state IDLE, out=0, presc=0, done_pulse=0, done_cnt=0, busy=0, cmd_ready=1. Reset mid-RUN aborts immediately; no done_pulse.
- Command latency: effect visible on out/state/busy the cycle after the accepting edge.
- START with prescale P: first increment at the (P+1)th edge after the accepting edge.
- Prescale 0: cmd_ready permanently 0 while in RUN; leaving RUN requires one-shot DONE or reset. Documented, intentional.
- Period with auto-reload: (cfg_limit+1)*(cfg_prescale+1) cycles between done_pulses.
- done_pulse high exactly one cycle, coincident with out=0 (reload) or state=DONE (one-shot).

## Test plan
- Reset: assert rst_n=0 mid-RUN with out=5 -> out=0, busy=0, done_pulse=0, cmd_ready=1 asynchronously.
- Auto-reload: limit=3, prescale=0, reload=1, START -> out 0,1,2,3,0,...; done_pulse every 4 cycles; done_cnt increments; cmd_ready=0 throughout RUN.
- One-shot with prescale: limit=2, prescale=2, reload=0, START -> out steps every 3 cycles 0,1,2; done_pulse once 9 cycles after start; state DONE, out holds 2; START -> out=0, RUN.
- Pause/resume: prescale=4, STOP at presc=2 -> out frozen 10 cycles; START -> next increment after 3 cycles (presc resumes at 2).
- Load beyond limit: limit=4, LOAD 0xFFFFFFFE in IDLE, START, prescale=0 -> out FFFFFFFF,0,1,...,4, done_pulse on tick at 4; no pulse on wrap.
- Handshake collision: prescale=1, issue STOP on tick cycle -> cmd_ready=0, held until next cycle, accepted; done_cnt saturation: 300 events -> 255.

Source files
------------

// File: rtl/counter_ctrl.sv
// Command-driven sequencer around a WIDTH-bit up-counter: prescaled ticks,
// limit compare with one-shot or auto-reload, and a saturating done count.
module counter_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_reload,
    input  logic [PW-1:0]    cfg_prescale,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done_pulse,
    output logic [7:0]       done_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    typedef enum logic [1:0] {OP_START, OP_STOP, OP_LOAD, OP_CLEAR} op_t;

    state_t           state, state_nx;
    op_t              op;
    logic [PW-1:0]    presc, presc_nx;
    logic [WIDTH-1:0] out_nx;
    logic             pulse_nx;
    logic [7:0]       dcnt_nx;
    logic             tick;
    logic             accept;

    assign op        = op_t'(cmd_op);
    assign tick      = (state == RUN) && (presc >= cfg_prescale);
    assign cmd_ready = !tick;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            out        <= '0;
            done_pulse <= 1'b0;
            done_cnt   <= '0;
        end else begin
            state      <= state_nx;
            presc      <= presc_nx;
            out        <= out_nx;
            done_pulse <= pulse_nx;
            done_cnt   <= dcnt_nx;
        end
    end

    // A tick blocks command acceptance, so counter updates and commands are exclusive.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        out_nx   = out;
        pulse_nx = 1'b0;
        dcnt_nx  = done_cnt;
        if (tick) begin
            presc_nx = '0;
            if (out == cfg_limit) begin
                pulse_nx = 1'b1;
                if (done_cnt != '1) dcnt_nx = done_cnt + 8'd1;
                if (cfg_reload) out_nx = '0;
                else            state_nx = DONE;
            end else begin
                out_nx = out + 1'b1;
            end
        end else begin
            if (state == RUN) presc_nx = presc + 1'b1;
            if (accept) begin
                unique case (state)
                    IDLE, PAUSED: begin
                        unique case (op)
                            OP_START: begin
                                state_nx = RUN;
                                if (state == IDLE) presc_nx = '0;
                            end
                            OP_LOAD:  out_nx = cmd_data;
                            OP_CLEAR: begin
                                out_nx  = '0;
                                dcnt_nx = '0;
                            end
                            default: ;
                        endcase
                    end
                    RUN: begin
                        unique case (op)
                            OP_STOP: begin
                                state_nx = PAUSED;
                                presc_nx = presc;
                            end
                            OP_LOAD: begin
                                out_nx   = cmd_data;
                                presc_nx = '0;
                            end
                            OP_CLEAR: begin
                                out_nx   = '0;
                                presc_nx = '0;
                                dcnt_nx  = '0;
                            end
                            default: ;
                        endcase
                    end
                    DONE: begin
                        state_nx = IDLE;
                        unique case (op)
                            OP_START: begin
                                out_nx   = '0;
                                presc_nx = '0;
                                state_nx = RUN;
                            end
                            OP_LOAD:  out_nx = cmd_data;
                            OP_CLEAR: begin
                                out_nx  = '0;
                                dcnt_nx = '0;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random
// commands/config, all compared against a behavioural cycle model.
module tb_counter_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    localparam logic [1:0] START = 2'd0, STOP = 2'd1, LOAD = 2'd2, CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] cfg_limit = '0;
    logic        cfg_reload = 1'b0;
    logic [7:0]  cfg_prescale = '0;
    logic [31:0] out;
    logic        busy;
    logic        done_pulse;
    logic [7:0]  done_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_state = M_IDLE;
    int          m_presc = 0;
    logic [31:0] m_out = '0;
    bit          m_pulse = 0;
    int          m_cnt = 0;

    counter_ctrl #(.WIDTH(32), .PW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cfg_limit(cfg_limit),
        .cfg_reload(cfg_reload), .cfg_prescale(cfg_prescale), .out(out),
        .busy(busy), .done_pulse(done_pulse), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_tick();
        return (m_state == M_RUN) && (m_presc >= int'(cfg_prescale));
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_presc = 0; m_out = '0; m_pulse = 0; m_cnt = 0;
    endtask

    // One rising edge of the behavioural model, using the inputs currently driven.
    task automatic model_step(output bit acc);
        bit tk;
        tk  = model_tick();
        acc = cmd_valid && !tk;
        m_pulse = 0;
        if (tk) begin
            m_presc = 0;
            if (m_out == cfg_limit) begin
                m_pulse = 1;
                m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (cfg_reload) m_out = 0;
                else            m_state = M_DONE;
            end else begin
                m_out = m_out + 1;
            end
        end else if (m_state == M_RUN) begin
            if (acc && cmd_op == STOP)       m_state = M_PAUSED;
            else if (acc && cmd_op == LOAD)  begin m_out = cmd_data; m_presc = 0; end
            else if (acc && cmd_op == CLEAR) begin m_out = 0; m_presc = 0; m_cnt = 0; end
            else                             m_presc = m_presc + 1;
        end else if (acc) begin
            case (cmd_op)
                START: begin
                    if (m_state == M_IDLE) m_presc = 0;
                    if (m_state == M_DONE) begin m_presc = 0; m_out = 0; end
                    m_state = M_RUN;
                end
                STOP:  if (m_state == M_DONE) m_state = M_IDLE;
                LOAD:  begin m_out = cmd_data; if (m_state == M_DONE) m_state = M_IDLE; end
                default: begin m_out = 0; m_cnt = 0; if (m_state == M_DONE) m_state = M_IDLE; end
            endcase
        end
    endtask

    // Called right after a falling edge; returns just after the next falling edge.
    task automatic step(output bit acc);
        #1 check("cmd_ready", 32'(cmd_ready), 32'(!model_tick()));
        @(posedge clk);
        model_step(acc);
        #1;
        check("out", out, m_out);
        check("busy", 32'(busy), 32'(m_state == M_RUN));
        check("done_pulse", 32'(done_pulse), 32'(m_pulse));
        check("done_cnt", 32'(done_cnt), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] data, output int waits);
        bit acc;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        waits = 0; acc = 0;
        while (!acc && waits < 50) begin
            step(acc);
            if (!acc) waits++;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out", out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulse", 32'(done_pulse), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_cnt", 32'(done_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int w, k, pulses, first_change;
        bit a;
        logic [31:0] held;

        @(negedge clk);
        do_reset();

        // auto-reload, prescale 0
        cfg_limit = 3; cfg_prescale = 0; cfg_reload = 1;
        send_cmd(START, 0, w);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin step(a); pulses += int'(done_pulse); end
        check("reload_pulses", 32'(pulses), 32'd2);

        // reset mid-RUN at out=5
        cfg_limit = 10;
        k = 0;
        while (m_out != 5 && k < 40) begin step(a); k++; end
        check("reach_out5", out, 32'd5);
        do_reset();

        // one-shot with prescale 2
        cfg_limit = 2; cfg_prescale = 2; cfg_reload = 0;
        send_cmd(START, 0, w);
        first_change = 0; pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            step(a);
            if (done_pulse) begin pulses++; first_change = i; end
        end
        check("oneshot_pulses", 32'(pulses), 32'd1);
        check("oneshot_edge", 32'(first_change), 32'd9);
        check("oneshot_out", out, 32'd2);
        check("oneshot_busy", 32'(busy), 32'd0);
        idle(3);
        send_cmd(START, 0, w);
        check("restart_out", out, 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        // pause at presc=2, resume
        cfg_prescale = 4; cfg_reload = 1; cfg_limit = 100;
        k = 0;
        while (!(m_presc == 2 && !model_tick()) && k < 20) begin step(a); k++; end
        send_cmd(STOP, 0, w);
        held = m_out;
        idle(10);
        check("paused_out", out, held);
        send_cmd(START, 0, w);
        first_change = 0;
        for (int i = 1; i <= 10 && first_change == 0; i++) begin
            step(a);
            if (out !== held) first_change = i;
        end
        check("resume_edges", 32'(first_change), 32'd3);

        // load beyond limit wraps through zero
        @(negedge clk);
        do_reset();
        cfg_limit = 4; cfg_prescale = 0; cfg_reload = 0;
        send_cmd(LOAD, 32'hFFFF_FFFE, w);
        send_cmd(START, 0, w);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin step(a); pulses += int'(done_pulse); end
        check("wrap_pulses", 32'(pulses), 32'd1);
        check("wrap_out", out, 32'd4);
        check("wrap_busy", 32'(busy), 32'd0);

        // command on a tick cycle must wait one cycle
        do_reset();
        cfg_limit = 100; cfg_prescale = 1; cfg_reload = 1;
        send_cmd(START, 0, w);
        k = 0;
        while (!model_tick() && k < 10) begin step(a); k++; end
        send_cmd(STOP, 0, w);
        check("collision_waits", 32'(w), 32'd1);
        check("collision_busy", 32'(busy), 32'd0);

        // done_cnt saturation
        do_reset();
        cfg_limit = 0; cfg_prescale = 0; cfg_reload = 1;
        send_cmd(START, 0, w);
        idle(300);
        check("sat_cnt", 32'(done_cnt), 32'd255);

        // randomized commands and configuration
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                cfg_limit    = $urandom_range(0, 12);
                cfg_prescale = 8'($urandom_range(0, 4));
                cfg_reload   = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 19) == 0) cfg_prescale = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cmd_valid = ($urandom_range(0, 9) < 3);
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_data  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
                step(a);
            end
        end
        cmd_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
